// File: rtl/cl_pkg.sv
// Shared definitions for the cl_pipe ALU pipeline: operation encodings used by
// the RTL and by any environment that drives it.
package cl_pkg;

  localparam int unsigned ClopWidth = 3;

  // Operation select encodings
  localparam logic [ClopWidth-1:0] CL_AND  = 3'b000;
  localparam logic [ClopWidth-1:0] CL_OR   = 3'b001;
  localparam logic [ClopWidth-1:0] CL_XOR  = 3'b010;
  localparam logic [ClopWidth-1:0] CL_NOTA = 3'b011;
  localparam logic [ClopWidth-1:0] CL_ADD  = 3'b100;
  localparam logic [ClopWidth-1:0] CL_SUB  = 3'b101;
  localparam logic [ClopWidth-1:0] CL_PASS = 3'b110;
  localparam logic [ClopWidth-1:0] CL_NAND = 3'b111;

endpackage

// File: rtl/cl_core.sv
// Stateless operation and flag evaluation for one cl_pipe operation.
// carry is the add carry-out, or "no borrow" (a >= b) for subtract, else 0.
module cl_core
  import cl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ClopWidth-1:0] clop,
  output logic [WIDTH-1:0]     out,
  output logic                 zero,
  output logic                 carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Widened add/sub so the top bit holds carry-out / borrow
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
  end

  // Result select and flags
  always_comb begin
    out   = '0;
    carry = 1'b0;
    unique case (clop)
      CL_AND:  out = a & b;
      CL_OR:   out = a | b;
      CL_XOR:  out = a ^ b;
      CL_NOTA: out = ~a;
      CL_ADD: begin
        out   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      CL_SUB: begin
        out   = diff[WIDTH-1:0];
        // Borrow out of the widened subtract means a < b
        carry = ~diff[WIDTH];
      end
      CL_PASS: out = b;
      CL_NAND: out = ~(a & b);
      default: out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/cl_pipe.sv
// Two-stage valid/ready ALU pipeline. S1 captures the operands and operation,
// S2 holds the computed result and flags presented to downstream. Each stage
// advances when it is empty or its contents move on, giving full throughput
// with back-pressure and no loss when accept and consume coincide.
module cl_pipe
  import cl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ClopWidth-1:0] clop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 zero,
  output logic                 carry
);

  // Stage 1 registers
  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_a_q;
  logic [WIDTH-1:0]     s1_b_q;
  logic [ClopWidth-1:0] s1_op_q;

  // Stage 2 registers
  logic                 s2_valid_q;
  logic [WIDTH-1:0]     s2_out_q;
  logic                 s2_zero_q;
  logic                 s2_carry_q;

  // Core results for the operation sitting in S1
  logic [WIDTH-1:0]     core_out;
  logic                 core_zero;
  logic                 core_carry;

  logic s2_adv;
  logic s1_adv;

  // Stage advance conditions; in_ready never looks at in_valid
  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    in_ready = s1_adv;
  end

  cl_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .clop (s1_op_q),
    .out  (core_out),
    .zero (core_zero),
    .carry(core_carry)
  );

  // S1: capture an offered operation whenever the stage can advance
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_op_q <= clop;
      end
    end
  end

  // S2: register the result; hold everything while stalled by downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_carry_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_out_q   <= core_out;
        s2_zero_q  <= core_zero;
        s2_carry_q <= core_carry;
      end
    end
  end

  // Outputs come straight from S2 registers
  always_comb begin
    out_valid = s2_valid_q;
    out       = s2_out_q;
    zero      = s2_zero_q;
    carry     = s2_carry_q;
  end

endmodule

// File: tb/tb_cl_pipe.sv
// Bench for cl_pipe: three instances (WIDTH 4, 1, 8) share clock and reset.
// A scoreboard queue receives the modelled result of every accepted operation
// and a monitor thread retires entries as each instance delivers results.
module tb_cl_pipe;
  import cl_pkg::*;

  localparam int NLanes = 3;

  typedef struct {
    int          lane;
    logic [31:0] res;
    logic        z;
    logic        c;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        iv   [NLanes];
  logic        ordy [NLanes];
  logic [7:0]  a_s  [NLanes];
  logic [7:0]  b_s  [NLanes];
  logic [2:0]  op_s [NLanes];
  logic        ir   [NLanes];
  logic        ov   [NLanes];
  logic        zf   [NLanes];
  logic        cf   [NLanes];
  logic [31:0] out_s[NLanes];

  exp_t sbq[$];
  int   n_vec;
  int   n_err;
  int   n_out [NLanes];

  for (genvar g = 0; g < NLanes; g++) begin : g_lane
    localparam int unsigned W = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    logic [W-1:0] o_w;
    cl_pipe #(
      .WIDTH(W)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .a        (a_s[g][W-1:0]),
      .b        (b_s[g][W-1:0]),
      .clop     (op_s[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out      (o_w),
      .zero     (zf[g]),
      .carry    (cf[g])
    );
    assign out_s[g] = 32'(o_w);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lane_w(input int l);
    return (l == 0) ? 4 : ((l == 1) ? 1 : 8);
  endfunction

  // Reference: plain modular arithmetic on the operand values
  function automatic exp_t model(input int l, input logic [2:0] op,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    longint unsigned m, ua, ub, r;
    m  = 64'd1 << lane_w(l);
    ua = 64'(a) % m;
    ub = 64'(b) % m;
    e.lane = l;
    e.c    = 1'b0;
    case (op)
      CL_AND:  r = ua & ub;
      CL_OR:   r = ua | ub;
      CL_XOR:  r = ua ^ ub;
      CL_NOTA: r = (m - 1) - ua;
      CL_ADD: begin
        r   = (ua + ub) % m;
        e.c = (ua + ub) >= m;
      end
      CL_SUB: begin
        r   = (ua + m - ub) % m;
        e.c = ua >= ub;
      end
      CL_PASS: r = ub;
      default: r = (m - 1) - (ua & ub);
    endcase
    e.res = 32'(r);
    e.z   = (r == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pending(input int l);
    int n = 0;
    foreach (sbq[i]) if (sbq[i].lane == l) n++;
    return n;
  endfunction

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation (caller sits just after a rising edge); returns just
  // after the accepting edge with in_valid still high.
  task automatic send(input int l, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    bit ok = 0;
    iv[l]   = 1'b1;
    op_s[l] = op;
    a_s[l]  = a;
    b_s[l]  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ir[l] && !reset;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_ov(input int l);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      at_neg();
      seen = ov[l];
    end
    if (!seen) chk("out_valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_empty(input int l);
    for (int i = 0; i < 40 && pending(l) != 0; i++) at_neg();
    chk("drain_pending", 32'(pending(l)), 32'd0);
  endtask

  task automatic rand_lane(input int l, input int cycles);
    logic [7:0] mask = 8'((1 << lane_w(l)) - 1);
    for (int i = 0; i < cycles; i++) begin
      to_pos();
      iv[l]   = ($urandom_range(3) != 0);
      op_s[l] = 3'($urandom_range(7));
      a_s[l]  = 8'($urandom) & mask;
      b_s[l]  = 8'($urandom) & mask;
      ordy[l] = ($urandom_range(2) != 0);
    end
    to_pos();
    iv[l]   = 1'b0;
    ordy[l] = 1'b1;
  endtask

  // Monitor: retire results, check stall stability, record accepted ops
  task automatic monitor();
    bit          held  [NLanes];
    logic [31:0] h_out [NLanes];
    logic        h_z   [NLanes];
    logic        h_c   [NLanes];
    forever begin
      @(negedge clk);
      if (reset) begin
        sbq.delete();
        for (int l = 0; l < NLanes; l++) held[l] = 0;
      end else begin
        for (int l = 0; l < NLanes; l++) begin
          if (held[l]) begin
            chk("hold_valid", 32'(ov[l]), 32'd1);
            chk("hold_out", out_s[l], h_out[l]);
            chk("hold_flags", {30'd0, zf[l], cf[l]}, {30'd0, h_z[l], h_c[l]});
          end
          if (ov[l] && ordy[l]) begin
            int idx = -1;
            foreach (sbq[i]) if (idx < 0 && sbq[i].lane == l) idx = i;
            if (idx < 0) begin
              chk("unexpected_result", 32'(ov[l]), 32'd0);
            end else begin
              chk("result_out", out_s[l], sbq[idx].res);
              chk("result_zero", 32'(zf[l]), 32'(sbq[idx].z));
              chk("result_carry", 32'(cf[l]), 32'(sbq[idx].c));
              sbq.delete(idx);
              n_out[l]++;
            end
          end
          held[l]  = ov[l] && !ordy[l];
          h_out[l] = out_s[l];
          h_z[l]   = zf[l];
          h_c[l]   = cf[l];
          if (iv[l] && ir[l]) sbq.push_back(model(l, op_s[l], a_s[l], b_s[l]));
        end
      end
    end
  endtask

  initial begin
    int base;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int l = 0; l < NLanes; l++) begin
      iv[l]    = 1'b0;
      ordy[l]  = 1'b0;
      a_s[l]   = '0;
      b_s[l]   = '0;
      op_s[l]  = '0;
      n_out[l] = 0;
    end
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    at_neg();
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_out", out_s[0], 32'd0);
    chk("rst_flags", {30'd0, zf[0], cf[0]}, 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd1);

    // Latency: OR 0,1 appears two edges after being offered
    to_pos();
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    op_s[0] = CL_OR;
    a_s[0]  = 8'd0;
    b_s[0]  = 8'd1;
    at_neg();
    chk("lat_in_ready", 32'(ir[0]), 32'd1);
    to_pos();
    iv[0] = 1'b0;
    at_neg();
    chk("lat_early_valid", 32'(ov[0]), 32'd0);
    to_pos();
    at_neg();
    chk("lat_valid", 32'(ov[0]), 32'd1);
    chk("lat_out", out_s[0], 32'd1);
    chk("lat_flags", {30'd0, zf[0], cf[0]}, 32'd0);

    // ADD wrap and SUB borrow
    to_pos();
    send(0, CL_ADD, 8'hf, 8'h1);
    iv[0] = 1'b0;
    wait_ov(0);
    chk("add_out", out_s[0], 32'd0);
    chk("add_flags", {30'd0, zf[0], cf[0]}, 32'd3);
    to_pos();
    send(0, CL_SUB, 8'h3, 8'h5);
    iv[0] = 1'b0;
    wait_ov(0);
    chk("sub_out", out_s[0], 32'he);
    chk("sub_flags", {30'd0, zf[0], cf[0]}, 32'd0);
    to_pos();
    wait_empty(0);

    // Back-pressure: two accepts fill the pipe, then in_ready drops
    to_pos();
    base    = n_out[0];
    ordy[0] = 1'b0;
    send(0, CL_XOR, 8'h5, 8'h3);
    send(0, CL_NAND, 8'h6, 8'hc);
    iv[0]   = 1'b1;
    op_s[0] = CL_PASS;
    b_s[0]  = 8'h9;
    at_neg();
    chk("bp_in_ready", 32'(ir[0]), 32'd0);
    chk("bp_out", out_s[0], 32'h6);
    repeat (3) at_neg();
    chk("bp_in_ready_late", 32'(ir[0]), 32'd0);
    chk("bp_out_held", out_s[0], 32'h6);
    to_pos();
    ordy[0] = 1'b1;
    send(0, CL_PASS, 8'h0, 8'h9);
    send(0, CL_NOTA, 8'h2, 8'h0);
    iv[0] = 1'b0;
    wait_empty(0);
    chk("bp_delivered", 32'(n_out[0] - base), 32'd4);

    // Full pipe with simultaneous accept and consume
    to_pos();
    base    = n_out[0];
    ordy[0] = 1'b0;
    send(0, CL_ADD, 8'h7, 8'h8);
    send(0, CL_AND, 8'hc, 8'ha);
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    op_s[0] = CL_SUB;
    a_s[0]  = 8'h9;
    b_s[0]  = 8'h4;
    at_neg();
    chk("full_in_ready", 32'(ir[0]), 32'd1);
    chk("full_out_valid", 32'(ov[0]), 32'd1);
    chk("full_pending", 32'(pending(0)), 32'd2);
    to_pos();
    iv[0] = 1'b0;
    at_neg();
    chk("full_next_valid", 32'(ov[0]), 32'd1);
    chk("full_next_out", out_s[0], 32'h8);
    wait_empty(0);
    chk("full_delivered", 32'(n_out[0] - base), 32'd3);

    // Reset with both stages full; offer during reset must be ignored
    to_pos();
    ordy[0] = 1'b0;
    send(0, CL_OR, 8'h1, 8'h2);
    send(0, CL_XOR, 8'hf, 8'h1);
    iv[0]   = 1'b0;
    base    = n_out[0];
    reset   = 1'b1;
    iv[0]   = 1'b1;
    op_s[0] = CL_PASS;
    b_s[0]  = 8'h5;
    to_pos();
    reset   = 1'b0;
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    at_neg();
    chk("rstmid_out_valid", 32'(ov[0]), 32'd0);
    chk("rstmid_in_ready", 32'(ir[0]), 32'd1);
    chk("rstmid_out", out_s[0], 32'd0);
    chk("rstmid_pending", 32'(pending(0)), 32'd0);
    repeat (6) at_neg();
    chk("rstmid_no_stale", 32'(n_out[0] - base), 32'd0);

    // Random traffic at WIDTH 1 and 8, plus more at WIDTH 4
    to_pos();
    fork
      rand_lane(0, 800);
      rand_lane(1, 1500);
      rand_lane(2, 1500);
    join
    for (int l = 0; l < NLanes; l++) wait_empty(l);
    chk("final_queue", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
